wb_cam_dvp_tx: RTL

//  Camera-side transmitter: Wishbone-loaded 512x32 word buffer replayed as a DVP pixel stream
//  (PCLKO/VSYNCO/HREFO/DATAO[7:0]). Drives the FPGA camera capture path for loopback tests and

---
 rtl/wb_cam_dvp_tx_pkg.sv | 48 ++++
 rtl/dvp_tx_timing.sv | 56 +++++
 rtl/r512x32_512x32.sv | 28 ++
 rtl/wb_cam_dvp_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_cam_dvp_tx_pkg.sv
// Shared types and constants for the Wishbone-loaded DVP transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_cam_dvp_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSTART,
    ST_LINE,
    ST_HGAP,
    ST_VEND
  } dvp_state_e;

  // Register indices on WBs_ADR_i[1:0]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_GEOM   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CONT_BIT  = 1;

  // GEOM field placement
  localparam int GEOM_WPL_LSB = 0;
  localparam int GEOM_WPL_W   = 9;
  localparam int GEOM_LPF_LSB = 16;
  localparam int GEOM_LPF_W   = 10;

  // Width of the PCLK-period counter
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [GEOM_LPF_W-1:0] lines;
    logic [GEOM_WPL_W-1:0] words;
  } geom_t;

  // Byte idx of a word, idx 0 is the most significant byte
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dvp_tx_timing.sv
// PCLKO divider, falling-edge tick and loadable PCLK-period down-counter.
// Latency: fall_tick_o is asserted in the clock whose edge drives PCLKO low.
// Backpressure: none; free-running after reset.
module dvp_tx_timing
  import wb_cam_dvp_tx_pkg::*;
#(
  parameter int PCLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_i,
  input  logic [CNT_W-1:0] ld_val_i,
  output logic             pclk_o,
  output logic             fall_tick_o,
  output logic             cnt_zero_o
);

  localparam logic [15:0] DIV_LAST = 16'(PCLK_DIV - 1);

  logic [15:0]      div_q, div_d;
  logic             pclk_q, pclk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             toggle;

  assign toggle      = (div_q == DIV_LAST);
  assign fall_tick_o = toggle & pclk_q;
  assign cnt_zero_o  = (cnt_q == '0);
  assign pclk_o      = pclk_q;

  // Divider: toggle PCLKO every PCLK_DIV clocks
  always_comb begin
    div_d  = toggle ? 16'd0 : div_q + 16'd1;
    pclk_d = pclk_q ^ toggle;
  end

  // Period counter: load wins, otherwise count down once per PCLKO period
  always_comb begin
    cnt_d = cnt_q;
    if (ld_i) cnt_d = ld_val_i;
    else if (fall_tick_o && (cnt_q != '0)) cnt_d = cnt_q - CNT_W'(1);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      pclk_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      div_q  <= div_d;
      pclk_q <= pclk_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/r512x32_512x32.sv
// 512x32 two-port RAM with per-byte write enables and registered read.
// Latency: read data one clock after the address.
// Backpressure: none; a read colliding with a write returns the old word.
module r512x32_512x32 (
  input  logic        wclk,
  input  logic        rclk,
  input  logic [8:0]  wa,
  input  logic [3:0]  wen,
  input  logic [31:0] wd,
  input  logic [8:0]  ra,
  output logic [31:0] rd
);

  logic [31:0] mem [0:511];

  // Byte-masked write port
  always_ff @(posedge wclk) begin
    for (int b = 0; b < 4; b++) begin
      if (wen[b]) mem[wa][8*b +: 8] <= wd[8*b +: 8];
    end
  end

  // Synchronous read port
  always_ff @(posedge rclk) begin
    rd <= mem[ra];
  end

endmodule

// File: rtl/wb_cam_dvp_tx.sv
// Replays a Wishbone-loaded 512x32 buffer as a DVP byte stream (PCLKO/VSYNCO/HREFO/DATAO).
// Latency: WB ACK one clock after STB; frame starts on the first falling PCLKO after START.
// Backpressure: none on DVP; WB is single-cycle ACK, buffer writable while busy.
module wb_cam_dvp_tx
  import wb_cam_dvp_tx_pkg::*;
#(
  parameter int ADDRWIDTH  = 9,
  parameter int DATAWIDTH  = 32,
  parameter int PCLK_DIV   = 2,
  parameter int HBLANK_PIX = 16,
  parameter int VBLANK_PIX = 64
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic [10:0]          WBs_ADR_i,
  input  logic                 WBs_BUF_CYC_i,
  input  logic                 WBs_REG_CYC_i,
  input  logic [3:0]           WBs_BYTE_STB_i,
  input  logic                 WBs_WE_i,
  input  logic                 WBs_STB_i,
  input  logic [DATAWIDTH-1:0] WBs_DAT_i,
  output logic [DATAWIDTH-1:0] WBs_DAT_o,
  output logic                 WBs_ACK_o,
  output logic                 PCLKO,
  output logic                 VSYNCO,
  output logic                 HREFO,
  output logic [7:0]           DATAO,
  output logic                 BUSY_o
);

  logic                 ack_q, ack_d;
  logic [31:0]          rdat_q, rdat_d;
  logic                 cont_q, cont_d;
  geom_t                geom_q, geom_d;
  logic                 start_pend_q, start_pend_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  dvp_state_e           state_q, state_d;
  logic                 vsync_q, vsync_d, href_q, href_d;
  logic [7:0]           data_q, data_d;
  logic [31:0]          sh_q, sh_d;
  logic [1:0]           byte_q, byte_d;
  logic [8:0]           words_left_q, words_left_d, wpl_q, wpl_d;
  logic [9:0]           lines_left_q, lines_left_d;
  logic [ADDRWIDTH-1:0] rd_ptr_q, rd_ptr_d;

  logic             wb_go, reg_wr, start_req, busy;
  logic [3:0]       buf_wen;
  logic [31:0]      rd_dat;
  logic             pclk, fall_tick, cnt_zero, ld, go_vstart, load_word;
  logic [CNT_W-1:0] ld_val;
  logic             unused_adr;

  assign unused_adr = ^WBs_ADR_i[10:9];
  assign busy       = (state_q != ST_IDLE);

  dvp_tx_timing #(.PCLK_DIV(PCLK_DIV)) u_timing (
    .clk        (WBs_CLK_i),
    .rst        (WBs_RST_i),
    .ld_i       (ld),
    .ld_val_i   (ld_val),
    .pclk_o     (pclk),
    .fall_tick_o(fall_tick),
    .cnt_zero_o (cnt_zero)
  );

  r512x32_512x32 u_buf (
    .wclk(WBs_CLK_i),
    .rclk(WBs_CLK_i),
    .wa  (WBs_ADR_i[8:0]),
    .wen (buf_wen),
    .wd  (WBs_DAT_i),
    .ra  (rd_ptr_q),
    .rd  (rd_dat)
  );

  // Wishbone slave: ACK, register writes, read mux, buffer write enables
  always_comb begin
    wb_go     = WBs_STB_i & ~ack_q;
    ack_d     = (WBs_BUF_CYC_i | WBs_REG_CYC_i) & WBs_STB_i & ~ack_q;
    reg_wr    = WBs_REG_CYC_i & wb_go & WBs_WE_i;
    buf_wen   = (WBs_BUF_CYC_i & wb_go & WBs_WE_i) ? WBs_BYTE_STB_i : 4'b0000;
    start_req = reg_wr && (WBs_ADR_i[1:0] == REG_CTRL) && WBs_DAT_i[CTRL_START_BIT];
    cont_d    = cont_q;
    geom_d    = geom_q;
    if (reg_wr && (WBs_ADR_i[1:0] == REG_CTRL)) cont_d = WBs_DAT_i[CTRL_CONT_BIT];
    if (reg_wr && (WBs_ADR_i[1:0] == REG_GEOM)) begin
      geom_d.words = WBs_DAT_i[GEOM_WPL_LSB +: GEOM_WPL_W];
      geom_d.lines = WBs_DAT_i[GEOM_LPF_LSB +: GEOM_LPF_W];
    end
    rdat_d = '0;
    if (WBs_REG_CYC_i && wb_go && !WBs_WE_i) begin
      case (WBs_ADR_i[1:0])
        REG_CTRL: rdat_d[CTRL_CONT_BIT] = cont_q;
        REG_GEOM: begin
          rdat_d[GEOM_WPL_LSB +: GEOM_WPL_W] = geom_q.words;
          rdat_d[GEOM_LPF_LSB +: GEOM_LPF_W] = geom_q.lines;
        end
        REG_STATUS: begin
          rdat_d[0]     = busy;
          rdat_d[31:16] = frame_cnt_q;
        end
        default: rdat_d = '0;
      endcase
    end
  end

  // Frame sequencer: every DVP output update happens on a falling-PCLKO tick
  always_comb begin
    state_d      = state_q;
    vsync_d      = vsync_q;
    href_d       = href_q;
    data_d       = data_q;
    sh_d         = sh_q;
    byte_d       = byte_q;
    words_left_d = words_left_q;
    lines_left_d = lines_left_q;
    wpl_d        = wpl_q;
    rd_ptr_d     = rd_ptr_q;
    frame_cnt_d  = frame_cnt_q;
    start_pend_d = start_pend_q;
    ld           = 1'b0;
    ld_val       = '0;
    go_vstart    = 1'b0;
    load_word    = 1'b0;
    // START is a single-clock pulse; hold it until the next falling tick
    if (start_req && !busy && (geom_q.lines != '0)) start_pend_d = 1'b1;
    if (fall_tick) begin
      case (state_q)
        ST_IDLE: go_vstart = start_pend_q;
        ST_VSTART, ST_HGAP: begin
          if (cnt_zero) begin
            state_d      = ST_LINE;
            href_d       = 1'b1;
            load_word    = 1'b1;
            words_left_d = wpl_q - 9'd1;  // 0 wraps to 511 => 512 words
          end
        end
        ST_LINE: begin
          if (byte_q != 2'd0) begin
            data_d = word_byte(sh_q, byte_q);
            byte_d = byte_q + 2'd1;
          end else if (words_left_q != '0) begin
            load_word    = 1'b1;
            words_left_d = words_left_q - 9'd1;
          end else begin
            href_d = 1'b0;
            data_d = 8'h00;
            ld     = 1'b1;
            if (lines_left_q == '0) begin
              state_d     = ST_VEND;
              vsync_d     = 1'b0;
              ld_val      = CNT_W'(VBLANK_PIX - 1);
              frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
              state_d      = ST_HGAP;
              ld_val       = CNT_W'(HBLANK_PIX - 1);
              lines_left_d = lines_left_q - 10'd1;
            end
          end
        end
        ST_VEND: begin
          if (cnt_zero) begin
            if (cont_q && (geom_q.lines != '0)) go_vstart = 1'b1;
            else state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Emit MSB of the prefetched word and advance the pointer to prefetch the next one
    if (load_word) begin
      data_d   = rd_dat[31:24];
      sh_d     = rd_dat;
      byte_d   = 2'd1;
      rd_ptr_d = rd_ptr_q + ADDRWIDTH'(1);
    end
    // Frame start: latch geometry and rewind the read pointer
    if (go_vstart) begin
      state_d      = ST_VSTART;
      vsync_d      = 1'b1;
      ld           = 1'b1;
      ld_val       = CNT_W'(HBLANK_PIX - 1);
      rd_ptr_d     = '0;
      wpl_d        = geom_q.words;
      lines_left_d = geom_q.lines - 10'd1;
      start_pend_d = 1'b0;
    end
  end

  // State registers; buffer contents are untouched by reset
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      ack_q        <= 1'b0;
      rdat_q       <= '0;
      cont_q       <= 1'b0;
      geom_q       <= '0;
      start_pend_q <= 1'b0;
      frame_cnt_q  <= '0;
      state_q      <= ST_IDLE;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      data_q       <= 8'h00;
      sh_q         <= '0;
      byte_q       <= '0;
      words_left_q <= '0;
      lines_left_q <= '0;
      wpl_q        <= '0;
      rd_ptr_q     <= '0;
    end else begin
      ack_q        <= ack_d;
      rdat_q       <= rdat_d;
      cont_q       <= cont_d;
      geom_q       <= geom_d;
      start_pend_q <= start_pend_d;
      frame_cnt_q  <= frame_cnt_d;
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      data_q       <= data_d;
      sh_q         <= sh_d;
      byte_q       <= byte_d;
      words_left_q <= words_left_d;
      lines_left_q <= lines_left_d;
      wpl_q        <= wpl_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  assign WBs_ACK_o = ack_q;
  assign WBs_DAT_o = rdat_q;
  assign PCLKO     = pclk;
  assign VSYNCO    = vsync_q;
  assign HREFO     = href_q;
  assign DATAO     = data_q;
  assign BUSY_o    = busy;

endmodule
